// File: rtl/bpsk_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_rx_pkg
// Description : Shared types and helpers for the BPSK frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package bpsk_rx_pkg;

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_PAYLOAD = 1'b1
    } rx_state_t;

    localparam logic [7:0] c_default_sync = 8'hD5;

    // Ceiling log2 usable in constant expressions; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpsk_integrate_dump.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_integrate_dump
// Description : Integrates signed samples over each bit period and emits a hard bit decision.
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_integrate_dump
    import bpsk_rx_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int SPB      = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic                o_bit_valid,
    output logic                o_bit_val
);

    localparam int c_ph_w  = clog2(SPB);
    localparam int c_acc_w = SAMPLE_W + clog2(SPB) + 1;

    logic signed [c_acc_w-1:0] r_acc;
    logic        [c_ph_w-1:0]  r_phase;
    logic signed [c_acc_w-1:0] w_sample_ext;
    logic signed [c_acc_w-1:0] w_sum;
    logic                      w_last;

    assign w_sample_ext = {{(c_acc_w-SAMPLE_W){i_sample[SAMPLE_W-1]}}, i_sample};
    assign w_sum        = r_acc + w_sample_ext;
    assign w_last       = (r_phase == c_ph_w'(SPB - 1));

    // Decision uses the sum including the current sample; zero counts as a 0 bit.
    assign o_bit_valid  = i_sample_valid && w_last;
    assign o_bit_val    = !w_sum[c_acc_w-1] && (w_sum != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (i_sample_valid) begin
            if (w_last) begin
                r_acc   <= '0;
                r_phase <= '0;
            end else begin
                r_acc   <= w_sum;
                r_phase <= r_phase + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpsk_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_frame_rx
// Description : BPSK demodulator with sliding sync-byte hunt and MSB-first payload assembly.
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_frame_rx
    import bpsk_rx_pkg::*;
#(
    parameter int         SAMPLE_W    = 8,
    parameter int         SPB         = 8,
    parameter logic [7:0] SYNC_WORD   = c_default_sync,
    parameter int         FRAME_BYTES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [7:0]          data_out,
    output logic                data_valid,
    output logic                frame_start,
    output logic                locked
);

    localparam int c_bc_w = clog2(FRAME_BYTES + 1);

    rx_state_t           r_state;
    logic [7:0]          r_window;
    logic [7:0]          r_byte;
    logic [2:0]          r_bit_cnt;
    logic [c_bc_w-1:0]   r_byte_cnt;
    logic                w_bit_valid;
    logic                w_bit_val;
    logic [7:0]          w_window_next;
    logic [7:0]          w_byte_next;

    bpsk_integrate_dump #(
        .SAMPLE_W (SAMPLE_W),
        .SPB      (SPB)
    ) u_integrate_dump (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_sample_valid (sample_valid),
        .i_sample       (sample_in),
        .o_bit_valid    (w_bit_valid),
        .o_bit_val      (w_bit_val)
    );

    assign w_window_next = {r_window[6:0], w_bit_val};
    assign w_byte_next   = {r_byte[6:0], w_bit_val};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_HUNT;
            r_window    <= ~SYNC_WORD;
            r_byte      <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= (r_state == ST_PAYLOAD);
            if (w_bit_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        r_window <= w_window_next;
                        if (w_window_next == SYNC_WORD) begin
                            r_state     <= ST_PAYLOAD;
                            frame_start <= 1'b1;
                            r_bit_cnt   <= '0;
                            r_byte_cnt  <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_byte    <= w_byte_next;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            data_out   <= w_byte_next;
                            data_valid <= 1'b1;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            // Window restarts clean so payload bits cannot form the next sync.
                            if (r_byte_cnt == c_bc_w'(FRAME_BYTES - 1)) begin
                                r_state    <= ST_HUNT;
                                r_window   <= ~SYNC_WORD;
                                r_byte_cnt <= '0;
                            end
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
